calc_key_ctrl: RTL and testbench
================================

Name: calc_key_ctrl

Overview:
- Front-end controller for the FPGA calculator; the initiator side of the ALU operand/result interface.
- Accepts decoded keypad codes and accumulates two decimal operands plus an operator.
- Presents num1/num2/op to the ALU, waits a fixed latency, then captures res/isValid.
- Drives the displayed value and status flags to the display stage.

Parameters:
- WIDTH, 16, operand/result width; matches the ALU num1/num2/res width.
- MAX_DIGITS, 4, maximum decimal digits per operand; 10^MAX_DIGITS-1 must fit in WIDTH.
- ALU_LAT, 1, cycles operands are held stable before res/isValid are sampled (>=1).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- key_valid, input, 1, key code present.
- key_code, input, 4, 0-9 digit; 10 '+'; 11 '-'; 12 '='; 13 clear; 14-15 ignored.
- key_ready, output, 1, controller can accept a key.
- num1, output, WIDTH, ALU operand A.
- num2, output, WIDTH, ALU operand B.
- op, output, 1, ALU operation: 0 sum, 1 subtract.
- res, input, WIDTH, ALU result.
- isValid, input, 1, ALU result-valid flag.
- display, output, WIDTH, value to show (entry accumulator or result).
- busy, output, 1, high in EXEC.
- done, output, 1, one-cycle pulse when a result is captured.
- err, output, 1, last operation had isValid=0; sticky until the next key is accepted.

Behaviour:
- Reset values: num1=0, num2=0, op=0, display=0, err=0, done=0, busy=0, key_ready=1, digit count=0, state ENTER_A.
- Reset asserted mid-operation, including during EXEC, aborts immediately; no done pulse.
- Key handshake: a key is accepted on a cycle with key_valid && key_ready.
  - key_ready = 0 only in EXEC; keys offered then are not consumed and must be held by the source.
  - Codes 14-15 are accepted and discarded.
- Digit accumulation: acc <= acc*10 + digit, computed at WIDTH+4 bits and truncated to WIDTH.
  - Digits beyond MAX_DIGITS are accepted and ignored; acc is unchanged.
  - Leading zeros count as digits.
- ENTER_A:
  - Digit: accumulates into num1; display=num1.
  - '+' / '-': op <= 0/1, digit count <= 0, goto ENTER_B, display stays num1.
  - '=': ignored.
- ENTER_B:
  - Digit: accumulates into num2; display=num2.
  - '+' / '-' with zero digits entered: replaces op.
  - '+' / '-' with at least one digit entered: ignored.
  - '=': goto EXEC with the current num2 (0 if no digits entered).
- EXEC:
  - num1/num2/op held constant; busy=1; counter runs ALU_LAT cycles.
  - Sample at the end of the last EXEC cycle:
    - isValid=1: display <= res, err <= 0.
    - isValid=0: display <= 0, err <= 1.
  - Then goto SHOW with done=1 for exactly that first SHOW cycle.
- SHOW:
  - Digit: num1 <= digit, num2 <= 0, count <= 1, err <= 0, goto ENTER_A.
  - '=': re-executes the same num1/num2/op; goto EXEC.
  - '+' / '-': see Optional Feature.
- Clear (13), accepted in any state except EXEC: num1=num2=0, op=0, display=0, err=0, count=0, goto ENTER_A.
- Timing: '=' accepted at edge T, busy=1 from T+1. The sample edge is T+ALU_LAT, and done/display update at T+ALU_LAT+1.
- Arithmetic wrap and signedness of res are the ALU's concern; res is passed through unchanged.

Optional Feature:
- Macro CALC_CHAIN_EN.
- Defined: '+'/'-' in SHOW loads num1 <= display (result), num2 <= 0, sets op, count <= 0, clears err, goto ENTER_B. If err=1, num1 <= 0.
- Undefined: '+'/'-' in SHOW are accepted and ignored; only digit, '=', or clear leave SHOW.

Test Plan:
- 1 '+' 1 '=' with the ALU model returning res=num1+num2, isValid=1, ALU_LAT=1 -> num1=1, num2=1, op=0 during EXEC; done pulses once 2 cycles after '=' accepted; display=2, err=0.
- 1,2 '-' 3,4 '=' with model returning res=num1-num2 -> op=1, num1=12, num2=34; display=16'hFFEA; done pulses once.
- Digits 1,2,3,4,5 -> num1=1234 (fifth ignored); key_valid held during EXEC -> key_ready=0, key not consumed until SHOW.
- Model forces isValid=0 -> err=1, display=0. A subsequent digit 7 -> err=0, num1=7, state ENTER_A.
- With CALC_CHAIN_EN: 5 '+' 3 '=' '+' 2 '=' -> display 8 then 10. Without it: second '+' is ignored; display remains 8 after the second '=' (re-execute).
- rst asserted during EXEC (ALU_LAT=3, one cycle after '=') -> next cycle all outputs at reset values, no done pulse, key_ready=1.

Source files
------------

// File: rtl/calc_key_ctrl.sv
// Calculator keypad front-end: builds two decimal operands plus an operator, drives the ALU, shows the result.
// Build option CALC_CHAIN_EN: '+'/'-' pressed after a result continues the calculation from that result.
module calc_key_ctrl #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic             op,
    input  logic [WIDTH-1:0] res,
    input  logic             isValid,
    output logic [WIDTH-1:0] display,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, SHOW} state_e;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int LAT_W = $clog2(ALU_LAT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_DIGITS);
    localparam logic [LAT_W-1:0] LAT_SAMPLE = LAT_W'(ALU_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(ALU_LAT);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   num1_q, num1_d;
    logic [WIDTH-1:0]   num2_q, num2_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   display_q, display_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [WIDTH-1:0]   res_cap_q, res_cap_d;
    logic               vld_cap_q, vld_cap_d;

    logic               key_fire;
    logic               is_digit;
    logic               is_opkey;
    logic               is_eq;
    logic               is_clr;
    logic               digit_room;
    logic [WIDTH-1:0]   acc_out;

    // Decimal shift-in at WIDTH+4 bits, truncated back to the operand width.
    function automatic logic [WIDTH-1:0] acc_digit(input logic [WIDTH-1:0] acc,
                                                   input logic [3:0]       digit);
        logic [WIDTH+3:0] wide;
        wide = {4'b0000, acc} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, digit};
        return wide[WIDTH-1:0];
    endfunction

    always_comb begin
        key_fire   = key_valid && key_ready;
        is_digit   = key_code <= 4'd9;
        is_opkey   = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
        is_eq      = key_code == KEY_EQ;
        is_clr     = key_code == KEY_CLR;
        digit_room = cnt_q < MAX_CNT;
        acc_out    = acc_digit((state_q == ENTER_B) ? num2_q : num1_q, key_code);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ENTER_A: if (key_fire && is_opkey) state_d = ENTER_B;
            ENTER_B: if (key_fire && is_eq)    state_d = EXEC;
            EXEC:    if (lat_q == LAT_LAST)    state_d = SHOW;
            SHOW: begin
                if (key_fire && is_digit)   state_d = ENTER_A;
                else if (key_fire && is_eq) state_d = EXEC;
`ifdef CALC_CHAIN_EN
                else if (key_fire && is_opkey) state_d = ENTER_B;
`endif
            end
            default: state_d = ENTER_A;
        endcase
        // key_fire is never set in EXEC, so clear cannot abort a calculation.
        if (key_fire && is_clr) state_d = ENTER_A;
    end

    always_comb begin
        busy      = state_q == EXEC;
        key_ready = state_q != EXEC;
        num1      = num1_q;
        num2      = num2_q;
        op        = op_q;
        display   = display_q;
        err       = err_q;
        done      = done_q;
    end

    // NOTE: every next-state value gets a default first, so no path can infer a latch.
    always_comb begin
        num1_d    = num1_q;
        num2_d    = num2_q;
        op_d      = op_q;
        display_d = display_q;
        err_d     = err_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        lat_d     = '0;
        res_cap_d = res_cap_q;
        vld_cap_d = vld_cap_q;

        if (key_fire) err_d = 1'b0;

        case (state_q)
            ENTER_A: begin
                if (key_fire && is_digit && digit_room) begin
                    num1_d    = acc_out;
                    display_d = acc_out;
                    cnt_d     = cnt_q + 1'b1;
                end else if (key_fire && is_opkey) begin
                    op_d   = key_code == KEY_MINUS;
                    num2_d = '0;
                    cnt_d  = '0;
                end
            end
            ENTER_B: begin
                if (key_fire && is_digit && digit_room) begin
                    num2_d    = acc_out;
                    display_d = acc_out;
                    cnt_d     = cnt_q + 1'b1;
                end else if (key_fire && is_opkey && cnt_q == '0) begin
                    op_d = key_code == KEY_MINUS;
                end
            end
            EXEC: begin
                if (lat_q != LAT_LAST) lat_d = lat_q + 1'b1;
                if (lat_q == LAT_SAMPLE) begin
                    res_cap_d = res;
                    vld_cap_d = isValid;
                end
                if (lat_q == LAT_LAST) begin
                    display_d = vld_cap_q ? res_cap_q : '0;
                    err_d     = !vld_cap_q;
                    done_d    = 1'b1;
                end
            end
            SHOW: begin
                if (key_fire && is_digit) begin
                    num1_d    = {{(WIDTH-4){1'b0}}, key_code};
                    num2_d    = '0;
                    display_d = {{(WIDTH-4){1'b0}}, key_code};
                    cnt_d     = CNT_W'(1);
                end
`ifdef CALC_CHAIN_EN
                else if (key_fire && is_opkey) begin
                    // A failed result must not leak into the next operand.
                    num1_d = err_q ? '0 : display_q;
                    num2_d = '0;
                    op_d   = key_code == KEY_MINUS;
                    cnt_d  = '0;
                end
`endif
            end
            default: ;
        endcase

        if (key_fire && is_clr) begin
            num1_d    = '0;
            num2_d    = '0;
            op_d      = 1'b0;
            display_d = '0;
            err_d     = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num1_q    <= '0;
            num2_q    <= '0;
            op_q      <= 1'b0;
            display_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            lat_q     <= '0;
            res_cap_q <= '0;
            vld_cap_q <= 1'b0;
        end else begin
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            op_q      <= op_d;
            display_q <= display_d;
            err_q     <= err_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            res_cap_q <= res_cap_d;
            vld_cap_q <= vld_cap_d;
        end
    end

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Directed bench for calc_key_ctrl: one instance at ALU_LAT=1, a second at ALU_LAT=3 for latency/abort cases.
module tb_calc_key_ctrl;

    logic        clk;
    int          checks;
    int          errors;

    logic        rst, key_valid, key_ready, op, is_valid, busy, done, err, alu_bad;
    logic [3:0]  key_code;
    logic [15:0] num1, num2, res, display;

    logic        rst_3, key_valid_3, key_ready_3, op_3, is_valid_3, busy_3, done_3, err_3;
    logic [3:0]  key_code_3;
    logic [15:0] num1_3, num2_3, res_3, display_3;

    calc_key_ctrl #(.WIDTH(16), .MAX_DIGITS(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .num1(num1), .num2(num2), .op(op), .res(res), .isValid(is_valid),
        .display(display), .busy(busy), .done(done), .err(err)
    );

    calc_key_ctrl #(.WIDTH(16), .MAX_DIGITS(4), .ALU_LAT(3)) dut_3 (
        .clk(clk), .rst(rst_3), .key_valid(key_valid_3), .key_code(key_code_3), .key_ready(key_ready_3),
        .num1(num1_3), .num2(num2_3), .op(op_3), .res(res_3), .isValid(is_valid_3),
        .display(display_3), .busy(busy_3), .done(done_3), .err(err_3)
    );

    // Combinational ALU models.
    assign res        = op ? num1 - num2 : num1 + num2;
    assign is_valid   = !alu_bad;
    assign res_3      = op_3 ? num1_3 - num2_3 : num1_3 + num2_3;
    assign is_valid_3 = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic press3(input logic [3:0] c);
        @(negedge clk);
        key_valid_3 = 1'b1;
        key_code_3  = c;
        @(posedge clk);
        #1;
        key_valid_3 = 1'b0;
    endtask

    // Presses '=' and follows the ALU_LAT=1 timeline: done two cycles after acceptance.
    task automatic run_equals(input logic [15:0] exp_disp, input logic exp_err,
                              input logic [15:0] exp_n1, input logic [15:0] exp_n2, input logic exp_op);
        press(4'd12);
        checks++;
        if ({busy, key_ready, num1, num2, op} !== {1'b1, 1'b0, exp_n1, exp_n2, exp_op}) begin
            errors++;
            $display("FAIL exec_operands got busy=%b rdy=%b n1=%h n2=%h op=%b exp n1=%h n2=%h op=%b",
                     busy, key_ready, num1, num2, op, exp_n1, exp_n2, exp_op);
        end
        step();
        checks++;
        if ({busy, done, num1, num2, op} !== {1'b1, 1'b0, exp_n1, exp_n2, exp_op}) begin
            errors++;
            $display("FAIL exec_hold got busy=%b done=%b n1=%h n2=%h op=%b", busy, done, num1, num2, op);
        end
        step();
        checks++;
        if ({busy, done, display, err} !== {1'b0, 1'b1, exp_disp, exp_err}) begin
            errors++;
            $display("FAIL result got busy=%b done=%b disp=%h err=%b exp disp=%h err=%b",
                     busy, done, display, err, exp_disp, exp_err);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single got done=%b exp 0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_3 = 1'b1;
        step();
        step();
        checks++;
        if ({num1, num2, op, display, err, done, busy, key_ready} !== {16'd0, 16'd0, 1'b0, 16'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset got n1=%h n2=%h op=%b disp=%h err=%b done=%b busy=%b rdy=%b",
                     num1, num2, op, display, err, done, busy, key_ready);
        end
        checks++;
        if ({num1_3, num2_3, op_3, display_3, err_3, done_3, busy_3, key_ready_3} !== {16'd0, 16'd0, 1'b0, 16'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_lat3 got n1=%h disp=%h busy=%b rdy=%b", num1_3, display_3, busy_3, key_ready_3);
        end
        @(negedge clk);
        rst = 1'b0; rst_3 = 1'b0;
    endtask

    task automatic test_add();
        press(4'd1);
        press(4'd10);
        press(4'd1);
        checks++;
        if ({num1, num2, op, display} !== {16'd1, 16'd1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL add_entry got n1=%h n2=%h op=%b disp=%h", num1, num2, op, display);
        end
        run_equals(16'd2, 1'b0, 16'd1, 16'd1, 1'b0);
    endtask

    task automatic test_sub();
        press(4'd13);
        press(4'd1); press(4'd2); press(4'd11); press(4'd3); press(4'd4);
        checks++;
        if ({num1, num2, op, display} !== {16'd12, 16'd34, 1'b1, 16'd34}) begin
            errors++;
            $display("FAIL sub_entry got n1=%h n2=%h op=%b disp=%h", num1, num2, op, display);
        end
        run_equals(16'hFFEA, 1'b0, 16'd12, 16'd34, 1'b1);
        // '=' from SHOW re-executes the same operation.
        run_equals(16'hFFEA, 1'b0, 16'd12, 16'd34, 1'b1);
    endtask

    task automatic test_misc_keys();
        press(4'd13);
        checks++;
        if ({num1, num2, op, display, err} !== {16'd0, 16'd0, 1'b0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL clear got n1=%h n2=%h op=%b disp=%h err=%b", num1, num2, op, display, err);
        end
        press(4'd4);
        press(4'd12);
        checks++;
        if ({busy, num1} !== {1'b0, 16'd4}) begin
            errors++;
            $display("FAIL eq_in_enter_a got busy=%b n1=%h exp busy=0 n1=0004", busy, num1);
        end
        press(4'd15);
        press(4'd10);
        press(4'd11);
        checks++;
        if ({num1, op, display} !== {16'd4, 1'b1, 16'd4}) begin
            errors++;
            $display("FAIL op_replace got n1=%h op=%b disp=%h", num1, op, display);
        end
        press(4'd6);
        press(4'd10);
        checks++;
        if ({num2, op, display} !== {16'd6, 1'b1, 16'd6}) begin
            errors++;
            $display("FAIL op_after_digit got n2=%h op=%b disp=%h", num2, op, display);
        end
        run_equals(16'hFFFE, 1'b0, 16'd4, 16'd6, 1'b1);
        press(4'd13);
        press(4'd0); press(4'd0); press(4'd0); press(4'd1); press(4'd2);
        checks++;
        if ({num1, display} !== {16'd1, 16'd1}) begin
            errors++;
            $display("FAIL leading_zeros got n1=%h disp=%h exp 0001", num1, display);
        end
    endtask

    task automatic test_digit_limit_hold();
        press(4'd13);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        checks++;
        if ({num1, display} !== {16'd1234, 16'd1234}) begin
            errors++;
            $display("FAIL digit_limit got n1=%0d disp=%0d exp 1234", num1, display);
        end
        press(4'd10);
        press(4'd1);
        press(4'd12);
        key_valid = 1'b1;
        key_code  = 4'd7;
        checks++;
        if ({key_ready, busy} !== 2'b01) begin
            errors++;
            $display("FAIL exec_not_ready got rdy=%b busy=%b exp rdy=0 busy=1", key_ready, busy);
        end
        step();
        checks++;
        if ({key_ready, num1, num2} !== {1'b0, 16'd1234, 16'd1}) begin
            errors++;
            $display("FAIL hold_in_exec got rdy=%b n1=%0d n2=%0d", key_ready, num1, num2);
        end
        step();
        checks++;
        if ({key_ready, done, num1, display} !== {1'b1, 1'b1, 16'd1234, 16'd1235}) begin
            errors++;
            $display("FAIL hold_show got rdy=%b done=%b n1=%0d disp=%0d exp 1 1 1234 1235",
                     key_ready, done, num1, display);
        end
        step();
        key_valid = 1'b0;
        checks++;
        if ({num1, num2, busy} !== {16'd7, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL held_key_taken got n1=%0d n2=%0d busy=%b exp 7 0 0", num1, num2, busy);
        end
    endtask

    task automatic test_invalid();
        press(4'd13);
        press(4'd9); press(4'd10); press(4'd1);
        alu_bad = 1'b1;
        run_equals(16'd0, 1'b1, 16'd9, 16'd1, 1'b0);
        alu_bad = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got err=%b exp 1", err);
        end
        press(4'd7);
        checks++;
        if ({err, num1, num2} !== {1'b0, 16'd7, 16'd0}) begin
            errors++;
            $display("FAIL err_clear got err=%b n1=%0d n2=%0d exp 0 7 0", err, num1, num2);
        end
        press(4'd8);
        checks++;
        if ({num1, display} !== {16'd78, 16'd78}) begin
            errors++;
            $display("FAIL enter_a_after_show got n1=%0d disp=%0d exp 78", num1, display);
        end
    endtask

    task automatic test_chain();
        press(4'd13);
        press(4'd5); press(4'd10); press(4'd3);
        run_equals(16'd8, 1'b0, 16'd5, 16'd3, 1'b0);
        press(4'd10);
`ifdef CALC_CHAIN_EN
        checks++;
        if ({num1, num2, op, display} !== {16'd8, 16'd0, 1'b0, 16'd8}) begin
            errors++;
            $display("FAIL chain_load got n1=%0d n2=%0d op=%b disp=%0d", num1, num2, op, display);
        end
        press(4'd2);
        run_equals(16'd10, 1'b0, 16'd8, 16'd2, 1'b0);
`else
        checks++;
        if ({num1, num2, op, display, busy} !== {16'd5, 16'd3, 1'b0, 16'd8, 1'b0}) begin
            errors++;
            $display("FAIL chain_ignored got n1=%0d n2=%0d op=%b disp=%0d", num1, num2, op, display);
        end
        run_equals(16'd8, 1'b0, 16'd5, 16'd3, 1'b0);
`endif
    endtask

    task automatic test_latency3();
        press3(4'd2); press3(4'd10); press3(4'd3); press3(4'd12);
        checks++;
        if (busy_3 !== 1'b1) begin
            errors++;
            $display("FAIL lat3_busy got busy=%b exp 1", busy_3);
        end
        step(); step(); step();
        checks++;
        if ({busy_3, done_3, display_3} !== {1'b1, 1'b0, 16'd3}) begin
            errors++;
            $display("FAIL lat3_wait got busy=%b done=%b disp=%0d exp 1 0 3", busy_3, done_3, display_3);
        end
        step();
        checks++;
        if ({busy_3, done_3, display_3, err_3} !== {1'b0, 1'b1, 16'd5, 1'b0}) begin
            errors++;
            $display("FAIL lat3_result got busy=%b done=%b disp=%0d err=%b exp 0 1 5 0",
                     busy_3, done_3, display_3, err_3);
        end
    endtask

    task automatic test_reset_exec();
        press3(4'd13);
        press3(4'd2); press3(4'd10); press3(4'd3); press3(4'd12);
        rst_3 = 1'b1;
        step();
        checks++;
        if ({num1_3, num2_3, op_3, display_3, err_3, done_3, busy_3, key_ready_3} !== {16'd0, 16'd0, 1'b0, 16'd0, 4'b0001}) begin
            errors++;
            $display("FAIL reset_in_exec got n1=%h n2=%h op=%b disp=%h err=%b done=%b busy=%b rdy=%b",
                     num1_3, num2_3, op_3, display_3, err_3, done_3, busy_3, key_ready_3);
        end
        @(negedge clk);
        rst_3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({done_3, busy_3, display_3} !== {1'b0, 1'b0, 16'd0}) begin
                errors++;
                $display("FAIL no_done_after_abort cycle %0d got done=%b busy=%b disp=%h", i, done_3, busy_3, display_3);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        key_valid = 1'b0; key_code = 4'd0; alu_bad = 1'b0;
        key_valid_3 = 1'b0; key_code_3 = 4'd0;
        rst = 1'b1; rst_3 = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_misc_keys();
        test_digit_limit_hold();
        test_invalid();
        test_chain();
        test_latency3();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
